// File: rtl/approx_add_pkg.sv
// Shared definitions for the pipelined approximate adder: mode encoding,
// the lower-part-OR helper and a saturating accumulator helper.
package approx_add_pkg;

  localparam logic MODE_EXACT = 1'b0;
  localparam logic MODE_LOA   = 1'b1;

  // Widest operand/accumulator the helpers handle
  localparam int unsigned MAX_W = 64;

  // LOA low field in bits [k-1:0] with its speculative carry at bit k (k < MAX_W)
  function automatic logic [MAX_W-1:0] loa_low(input logic [MAX_W-1:0] a,
                                               input logic [MAX_W-1:0] b,
                                               input int unsigned      k);
    logic [MAX_W-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < MAX_W; i++) begin
      if (i < k) r[i] = a[i] | b[i];
    end
    for (int unsigned i = 1; i < MAX_W; i++) begin
      if (i == k) r[i] = a[i-1] & b[i-1];
    end
    return r;
  endfunction

  // acc + inc clamped to 2^w - 1 (w <= MAX_W)
  function automatic logic [MAX_W-1:0] sat_inc(input logic [MAX_W-1:0] acc,
                                               input logic [MAX_W-1:0] inc,
                                               input int unsigned      w);
    logic [MAX_W:0] s;
    logic [MAX_W:0] lim;
    s   = {1'b0, acc} + {1'b0, inc};
    lim = ((MAX_W+1)'(1) << w) - (MAX_W+1)'(1);
    return MAX_W'((s > lim) ? lim : s);
  endfunction

endpackage

// File: rtl/approx_err_mon.sv
// Online approximation-error statistics; compiled only with APPROX_ERR_MON_EN.
`ifdef APPROX_ERR_MON_EN
module approx_err_mon
  import approx_add_pkg::*;
#(
  parameter int unsigned W     = 8,
  parameter int unsigned ACC_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             upd,
  input  logic [W:0]       e,
  output logic [ACC_W-1:0] err_sum,
  output logic [W:0]       err_max,
  output logic [ACC_W-1:0] err_cnt
);

  logic [ACC_W-1:0] err_sum_q, err_sum_d;
  logic [W:0]       err_max_q, err_max_d;
  logic [ACC_W-1:0] err_cnt_q, err_cnt_d;

  // Clear takes priority over a coincident sample
  always_comb begin
    err_sum_d = err_sum_q;
    err_max_d = err_max_q;
    err_cnt_d = err_cnt_q;
    if (clr) begin
      err_sum_d = '0;
      err_max_d = '0;
      err_cnt_d = '0;
    end else if (upd) begin
      err_sum_d = ACC_W'(sat_inc(MAX_W'(err_sum_q), MAX_W'(e), ACC_W));
      if (e > err_max_q) err_max_d = e;
      err_cnt_d = ACC_W'(sat_inc(MAX_W'(err_cnt_q), MAX_W'(e != '0), ACC_W));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_sum_q <= '0;
      err_max_q <= '0;
      err_cnt_q <= '0;
    end else begin
      err_sum_q <= err_sum_d;
      err_max_q <= err_max_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_sum = err_sum_q;
  assign err_max = err_max_q;
  assign err_cnt = err_cnt_q;

endmodule
`endif

// File: rtl/approx_add_pipe.sv
// Two-stage valid/ready adder with a runtime LOA approximation on the low LOW_K bits.
// Define APPROX_ERR_MON_EN to build the online error monitor.
module approx_add_pipe
  import approx_add_pkg::*;
#(
  parameter int unsigned W     = 8,
  parameter int unsigned LOW_K = 4,
  parameter int unsigned ACC_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  input  logic             in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W:0]       out_sum,
  input  logic             err_clr,
  output logic [ACC_W-1:0] err_sum,
  output logic [W:0]       err_max,
  output logic [ACC_W-1:0] err_cnt
);

  localparam int unsigned SW = W + 1;
  localparam logic [W-1:0] LOW_MASK = W'((SW'(1) << LOW_K) - SW'(1));

  logic         s1_valid_q, s1_valid_d;
  logic [W-1:0] s1_a_q, s1_a_d;
  logic [W-1:0] s1_b_q, s1_b_d;
  logic [W-1:0] s1_low_q, s1_low_d;
  logic         s1_c_q, s1_c_d;
  logic         out_valid_q, out_valid_d;
  logic [W:0]   out_sum_q, out_sum_d;

  logic         s2_advance;
  logic         in_xfer;
  logic [W-1:0] exact_low;
  logic [W-1:0] loa_sum;
  logic [W:0]   hi_sum;
  logic [W:0]   s2_sum;

  always_comb begin
    s2_advance = !out_valid_q || out_ready;
    in_ready   = !s1_valid_q || s2_advance;
    in_xfer    = in_valid && in_ready;
  end

  // Stage 1: low field and carry into the upper part; carry lands at bit LOW_K
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_low_d   = s1_low_q;
    s1_c_d     = s1_c_q;
    exact_low  = (in_a & LOW_MASK) + (in_b & LOW_MASK);
    loa_sum    = W'(loa_low(MAX_W'(in_a), MAX_W'(in_b), LOW_K));
    if (in_ready) s1_valid_d = in_valid;
    if (in_xfer) begin
      s1_a_d = in_a;
      s1_b_d = in_b;
      if (in_mode == MODE_LOA) begin
        s1_low_d = loa_sum & LOW_MASK;
        s1_c_d   = loa_sum[LOW_K];
      end else begin
        s1_low_d = exact_low & LOW_MASK;
        s1_c_d   = exact_low[LOW_K];
      end
    end
  end

  // Stage 2: exact upper sum, concatenated with the stage-1 low field
  always_comb begin
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    hi_sum      = SW'(s1_a_q >> LOW_K) + SW'(s1_b_q >> LOW_K) + SW'(s1_c_q);
    s2_sum      = (hi_sum << LOW_K) | SW'(s1_low_q);
    if (s2_advance) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) out_sum_d = s2_sum;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_low_q    <= '0;
      s1_c_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_low_q    <= s1_low_d;
      s1_c_q      <= s1_c_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;

`ifdef APPROX_ERR_MON_EN
  logic [W:0] exact_sum;
  logic [W:0] err_e_q, err_e_d;

  // Error travels with its result so the monitor samples it at the out handshake
  always_comb begin
    err_e_d   = err_e_q;
    exact_sum = SW'(s1_a_q) + SW'(s1_b_q);
    if (s2_advance && s1_valid_q) begin
      err_e_d = (exact_sum >= s2_sum) ? exact_sum - s2_sum : s2_sum - exact_sum;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_e_q <= '0;
    else        err_e_q <= err_e_d;
  end

  approx_err_mon #(
    .W     (W),
    .ACC_W (ACC_W)
  ) u_err_mon (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (err_clr),
    .upd     (out_valid_q && out_ready),
    .e       (err_e_q),
    .err_sum (err_sum),
    .err_max (err_max),
    .err_cnt (err_cnt)
  );
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign err_sum = '0;
  assign err_max = '0;
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_approx_add_pipe.sv
// Directed bench for approx_add_pipe: default build, an exact LOW_K=0 build and a
// narrow-accumulator build share one stimulus stream.
module tb_approx_add_pipe;

  localparam int unsigned W     = 8;
  localparam int unsigned ACC_W = 32;
  localparam int unsigned SAT_W = 3;
  localparam logic [63:0] SAT_MAX = 64'd7;
`ifdef APPROX_ERR_MON_EN
  localparam bit MON = 1'b1;
`else
  localparam bit MON = 1'b0;
`endif

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         mode;
    logic [W:0]   exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid, in_mode, out_ready, err_clr;
  logic [W-1:0] in_a, in_b;

  logic in_ready, out_valid;
  logic [W:0] out_sum, err_max;
  logic [ACC_W-1:0] err_sum, err_cnt;

  logic k0_in_ready, k0_out_valid;
  logic [W:0] k0_out_sum, k0_err_max;
  logic [ACC_W-1:0] k0_err_sum, k0_err_cnt;

  logic st_in_ready, st_out_valid;
  logic [W:0] st_out_sum, st_err_max;
  logic [SAT_W-1:0] st_err_sum, st_err_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  logic [63:0] m_sum = 0, m_max = 0, m_cnt = 0, s_sum = 0, s_cnt = 0;
  vec_t vecs [10];

  always #5 clk = ~clk;

  approx_add_pipe #(.W(W), .LOW_K(4), .ACC_W(ACC_W)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_mode(in_mode), .out_valid(out_valid),
    .out_ready(out_ready), .out_sum(out_sum), .err_clr(err_clr),
    .err_sum(err_sum), .err_max(err_max), .err_cnt(err_cnt));

  approx_add_pipe #(.W(W), .LOW_K(0), .ACC_W(ACC_W)) u_k0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(k0_in_ready),
    .in_a(in_a), .in_b(in_b), .in_mode(in_mode), .out_valid(k0_out_valid),
    .out_ready(out_ready), .out_sum(k0_out_sum), .err_clr(err_clr),
    .err_sum(k0_err_sum), .err_max(k0_err_max), .err_cnt(k0_err_cnt));

  approx_add_pipe #(.W(W), .LOW_K(4), .ACC_W(SAT_W)) u_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(st_in_ready),
    .in_a(in_a), .in_b(in_b), .in_mode(in_mode), .out_valid(st_out_valid),
    .out_ready(out_ready), .out_sum(st_out_sum), .err_clr(err_clr),
    .err_sum(st_err_sum), .err_max(st_err_max), .err_cnt(st_err_cnt));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mon_clear();
    m_sum = 0; m_max = 0; m_cnt = 0; s_sum = 0; s_cnt = 0;
  endtask

  // Expected monitor effect of one delivered result
  task automatic mon_upd(input logic [W:0] res, input logic [W:0] exact);
    logic [63:0] e;
    e = (exact > res) ? 64'(exact - res) : 64'(res - exact);
    if (MON) begin
      m_sum = m_sum + e;
      if (e > m_max) m_max = e;
      if (e != 0) m_cnt = m_cnt + 1;
      s_sum = (s_sum + e > SAT_MAX) ? SAT_MAX : s_sum + e;
      if (e != 0) s_cnt = (s_cnt + 1 > SAT_MAX) ? SAT_MAX : s_cnt + 1;
    end
  endtask

  task automatic check_err(input string tag);
    check({tag, " err_sum"}, 64'(err_sum), m_sum);
    check({tag, " err_max"}, 64'(err_max), m_max);
    check({tag, " err_cnt"}, 64'(err_cnt), m_cnt);
    check({tag, " k0 err_cnt"}, 64'(k0_err_cnt), 64'd0);
    check({tag, " k0 err_sum"}, 64'(k0_err_sum), 64'd0);
    check({tag, " k0 err_max"}, 64'(k0_err_max), 64'd0);
    check({tag, " sat err_sum"}, 64'(st_err_sum), s_sum);
    check({tag, " sat err_cnt"}, 64'(st_err_cnt), s_cnt);
    check({tag, " sat err_max"}, 64'(st_err_max), m_max);
  endtask

  // One isolated transaction: latency 2, then drained
  task automatic run_vec(input vec_t v, input string tag);
    logic [W:0] exact;
    exact = (W+1)'(v.a) + (W+1)'(v.b);
    in_valid = 1'b1; in_a = v.a; in_b = v.b; in_mode = v.mode; out_ready = 1'b1;
    #1;
    check({tag, " in_ready"}, 64'(in_ready), 64'd1);
    check({tag, " sat in_ready"}, 64'(st_in_ready & k0_in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    check({tag, " out_valid at 1"}, 64'(out_valid), 64'd0);
    step();
    check({tag, " out_valid at 2"}, 64'(out_valid), 64'd1);
    check({tag, " out_sum"}, 64'(out_sum), 64'(v.exp));
    check({tag, " sat out_sum"}, 64'(st_out_sum & {(W+1){st_out_valid}}), 64'(v.exp));
    check({tag, " k0 out_sum"}, 64'(k0_out_sum & {(W+1){k0_out_valid}}), 64'(exact));
    mon_upd(v.exp, exact);
    step();
    check({tag, " out_valid drained"}, 64'(out_valid), 64'd0);
    check_err(tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{8'h0F, 8'h01, 1'b1, 9'h00F};
    vecs[1] = '{8'h0F, 8'h01, 1'b0, 9'h010};
    vecs[2] = '{8'hFF, 8'hFF, 1'b0, 9'h1FE};
    vecs[3] = '{8'hFF, 8'hFF, 1'b1, 9'h1FF};
    vecs[4] = '{8'hA5, 8'h3C, 1'b1, 9'h0DD};
    vecs[5] = '{8'h80, 8'h80, 1'b0, 9'h100};
    vecs[6] = '{8'h00, 8'h00, 1'b1, 9'h000};
    vecs[7] = '{8'h37, 8'h48, 1'b1, 9'h07F};
    vecs[8] = '{8'h08, 8'h08, 1'b1, 9'h018};
    vecs[9] = '{8'hAB, 8'h77, 1'b1, 9'h11F};

    in_valid = 1'b0; in_a = '0; in_b = '0; in_mode = 1'b0;
    out_ready = 1'b1; err_clr = 1'b0;
    #1;
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset out_sum", 64'(out_sum), 64'd0);
    check("reset in_ready", 64'(in_ready), 64'd1);
    check_err("reset");
    #12 rst_n = 1'b1;
    step();

    for (int i = 0; i < 10; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Backpressure: three offered, two accepted, output held, then in-order drain
    out_ready = 1'b0; in_valid = 1'b1;
    in_a = 8'h0F; in_b = 8'h0F; in_mode = 1'b1;
    step();
    in_a = 8'h12; in_b = 8'h34; in_mode = 1'b0;
    #1;
    check("bp in_ready one held", 64'(in_ready), 64'd1);
    step();
    in_a = 8'h21; in_b = 8'h42; in_mode = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("bp%0d in_ready", i), 64'(in_ready), 64'd0);
      check($sformatf("bp%0d out_valid", i), 64'(out_valid), 64'd1);
      check($sformatf("bp%0d out_sum held", i), 64'(out_sum), 64'h01F);
      step();
    end
    out_ready = 1'b1;
    #1;
    check("bp release in_ready", 64'(in_ready), 64'd1);
    mon_upd(9'h01F, 9'h01E);
    step();
    in_valid = 1'b0;
    check("bp second valid", 64'(out_valid), 64'd1);
    check("bp second sum", 64'(out_sum), 64'h046);
    mon_upd(9'h046, 9'h046);
    step();
    check("bp third valid", 64'(out_valid), 64'd1);
    check("bp third sum", 64'(out_sum), 64'h063);
    mon_upd(9'h063, 9'h063);
    step();
    check("bp drained", 64'(out_valid), 64'd0);
    check_err("bp");

    // Reset with two transactions in flight
    out_ready = 1'b0; in_valid = 1'b1;
    in_a = 8'h55; in_b = 8'hAA; in_mode = 1'b0;
    step();
    in_a = 8'h01; in_b = 8'h02;
    step();
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("midrst out_valid", 64'(out_valid), 64'd0);
    check("midrst out_sum", 64'(out_sum), 64'd0);
    check("midrst in_ready", 64'(in_ready), 64'd1);
    mon_clear();
    check_err("midrst");
    #3 rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("postrst%0d out_valid", i), 64'(out_valid), 64'd0);
    end
    run_vec(vecs[3], "postrst");

    // Clear coinciding with an out handshake: clear wins, sample dropped
    in_valid = 1'b1; in_a = 8'hFF; in_b = 8'hFF; in_mode = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    check("clr out_sum", 64'(out_sum), 64'h1FF);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    mon_clear();
    check("clr out_valid", 64'(out_valid), 64'd0);
    check_err("clr");
    run_vec(vecs[0], "afterclr");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
